// File: rtl/keynsham_dma_pkg.sv
// keynsham_dma_pkg
// Shared definitions for the keynsham single-channel DMA engine.
// Contents:
//   dma_state_e   - transfer sequencer states
//   REG_*         - word offsets of the four registers inside the window
//   CTRL_*        - bit positions inside CTRL/STATUS
//   BYTESEL_ALL   - the only byte-lane pattern the register port accepts
//   ptr_step()    - advance a 30-bit word pointer, wrapping silently at the top
package keynsham_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_FIN     = 3'd5,
      ST_ERRS    = 3'd6
   } dma_state_e;

   localparam logic [1:0] REG_SRC   = 2'd0;
   localparam logic [1:0] REG_DST   = 2'd1;
   localparam logic [1:0] REG_COUNT = 2'd2;
   localparam logic [1:0] REG_CTRL  = 2'd3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_DONE    = 1;
   localparam int CTRL_ERR     = 2;
   localparam int CTRL_IRQ_EN  = 3;
   localparam int CTRL_SRC_INC = 4;
   localparam int CTRL_DST_INC = 5;

   localparam logic [3:0] BYTESEL_ALL = 4'b1111;

   // Pointers are plain word addresses; a carry out of bit 29 is dropped.
   function automatic logic [29:0] ptr_step(input logic [29:0] ptr, input logic inc);
      return ptr + {29'd0, inc};
   endfunction

endpackage

// File: rtl/keynsham_bus_initiator.sv
// keynsham_bus_initiator
// Issues one access on the DMA's initiator port and waits for it to finish.
// A one-cycle req loads address/direction/data; m_access pulses for exactly the
// following cycle while m_addr/m_wr_en/m_wr_val stay put until the access ends.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req, req_addr, req_wr_en,
//   req_wr_val                   request from the sequencer (req is a pulse)
//   m_access, m_addr, m_wr_en,
//   m_wr_val, m_bytesel          registered initiator bus outputs
//   m_ack, m_error               responder completion / fault
//   xfer_done, xfer_err          same-cycle completion handshake to the sequencer
module keynsham_bus_initiator
   import keynsham_dma_pkg::*;
#(
   parameter int unsigned timeout_cycles = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [29:0] req_addr,
   input  logic        req_wr_en,
   input  logic [31:0] req_wr_val,
   output logic        m_access,
   output logic [29:0] m_addr,
   output logic        m_wr_en,
   output logic [31:0] m_wr_val,
   output logic [3:0]  m_bytesel,
   input  logic        m_ack,
   input  logic        m_error,
   output logic        xfer_done,
   output logic        xfer_err
);

   // A zero budget would never expire; treat it as a single waiting cycle.
   localparam logic [31:0] TMO_LOAD = (timeout_cycles == 0) ? 32'd1 : 32'(timeout_cycles);

   logic        access_r;
   logic [29:0] addr_r;
   logic        wr_en_r;
   logic [31:0] wr_val_r;
   logic [3:0]  bytesel_r;
   logic        pend_r;
   logic [31:0] tmr_r;
   logic        wait_s;
   logic        done_s;
   logic        err_s;

   // Responses count only after the request cycle; an ack on the expiry cycle beats the timeout.
   always_comb begin
      done_s = 1'b0;
      err_s  = 1'b0;
      wait_s = pend_r && !access_r;
      if (wait_s) begin
         if (m_error) begin
            err_s = 1'b1;
         end else if (m_ack) begin
            done_s = 1'b1;
         end else if (tmr_r <= 32'd1) begin
            err_s = 1'b1;
         end else begin
            err_s = 1'b0;
         end
      end else begin
         done_s = 1'b0;
      end
   end

   // Request launch, hold until completion, and the per-request timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         access_r  <= 1'b0;
         addr_r    <= 30'd0;
         wr_en_r   <= 1'b0;
         wr_val_r  <= 32'd0;
         bytesel_r <= 4'd0;
         pend_r    <= 1'b0;
         tmr_r     <= 32'd0;
      end else begin
         access_r <= req;
         if (req) begin
            addr_r    <= req_addr;
            wr_en_r   <= req_wr_en;
            wr_val_r  <= req_wr_en ? req_wr_val : 32'd0;
            bytesel_r <= BYTESEL_ALL;
            pend_r    <= 1'b1;
            tmr_r     <= TMO_LOAD;
         end else if (done_s || err_s) begin
            addr_r    <= 30'd0;
            wr_en_r   <= 1'b0;
            wr_val_r  <= 32'd0;
            bytesel_r <= 4'd0;
            pend_r    <= 1'b0;
            tmr_r     <= 32'd0;
         end else if (wait_s) begin
            tmr_r <= tmr_r - 32'd1;
         end
      end
   end

   assign m_access  = access_r;
   assign m_addr    = addr_r;
   assign m_wr_en   = wr_en_r;
   assign m_wr_val  = wr_val_r;
   assign m_bytesel = bytesel_r;
   assign xfer_done = done_s;
   assign xfer_err  = err_s;

endmodule

// File: rtl/keynsham_dma.sv
// keynsham_dma
// Single-channel memory-to-memory DMA: copies COUNT words from SRC to DST over
// a dedicated initiator port and raises a level interrupt on completion/error.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   bus_access, bus_addr, bus_wr_val,
//   bus_wr_en, bus_bytesel             CPU register-port request
//   bus_cs                             combinational window hit
//   bus_ack, bus_error, bus_data       registered register-port response
//   m_*                                initiator port (see keynsham_bus_initiator)
//   irq                                IRQ_EN && (DONE || ERR), registered
module keynsham_dma
   import keynsham_dma_pkg::*;
#(
   parameter logic [31:0] bus_address    = 32'h0,
   parameter logic [31:0] bus_size       = 32'h10,
   parameter int unsigned timeout_cycles = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_access,
   output logic        bus_cs,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_wr_val,
   input  logic        bus_wr_en,
   input  logic [3:0]  bus_bytesel,
   output logic        bus_ack,
   output logic        bus_error,
   output logic [31:0] bus_data,
   output logic        m_access,
   output logic [29:0] m_addr,
   output logic        m_wr_en,
   output logic [31:0] m_wr_val,
   output logic [3:0]  m_bytesel,
   input  logic [31:0] m_data,
   input  logic        m_ack,
   input  logic        m_error,
   output logic        irq
);

   localparam logic [29:0] BASE_WORD = bus_address[31:2];
   localparam logic [32:0] END_BYTE  = {1'b0, bus_address} + {1'b0, bus_size};

   dma_state_e  state_r, state_nx_s;
   logic [29:0] src_r, src_nx_s, dst_r, dst_nx_s;
   logic [15:0] count_r, count_nx_s;
   logic        done_r, done_nx_s, err_r, err_nx_s;
   logic        irq_en_r, irq_en_nx_s, src_inc_r, src_inc_nx_s, dst_inc_r, dst_inc_nx_s;
   logic        irq_r, irq_nx_s, bus_ack_r, bus_error_r;
   logic [31:0] bus_data_r;
   logic [32:0] byte_addr_s;
   logic [29:0] off_s;
   logic [1:0]  reg_sel_s;
   logic        cs_s, hit_s, reg_hit_s, wr_s, rd_s, busy_s, start_s;
   logic [31:0] rdata_s;
   logic        req_s, req_wr_en_s;
   logic [29:0] req_addr_s;
   logic [31:0] req_wr_val_s;
   logic        xfer_done_s, xfer_err_s;

   // Window decode; offsets beyond the four registers are acked but hit nothing.
   always_comb begin
      byte_addr_s = {1'b0, bus_addr, 2'b00};
      off_s       = bus_addr - BASE_WORD;
      reg_sel_s   = off_s[1:0];
      cs_s        = (byte_addr_s >= {1'b0, bus_address}) && (byte_addr_s < END_BYTE);
      hit_s       = bus_access && cs_s;
      reg_hit_s   = hit_s && (bus_bytesel == BYTESEL_ALL) && (off_s[29:2] == 28'd0);
      wr_s        = reg_hit_s && bus_wr_en;
      rd_s        = reg_hit_s && !bus_wr_en;
      busy_s      = (state_r != ST_IDLE);
      start_s     = wr_s && (reg_sel_s == REG_CTRL) && bus_wr_val[CTRL_START] && !busy_s;
   end

   // Register read mux; START reads back as BUSY.
   always_comb begin
      case (reg_sel_s)
         REG_SRC:   rdata_s = {2'b00, src_r};
         REG_DST:   rdata_s = {2'b00, dst_r};
         REG_COUNT: rdata_s = {16'd0, count_r};
         REG_CTRL:  rdata_s = {26'd0, dst_inc_r, src_inc_r, irq_en_r, err_r, done_r, busy_s};
         default:   rdata_s = 32'd0;
      endcase
   end

   // Register-port response, one cycle after the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_ack_r   <= 1'b0;
         bus_error_r <= 1'b0;
         bus_data_r  <= 32'd0;
      end else begin
         bus_ack_r   <= hit_s;
         bus_error_r <= hit_s && (bus_bytesel != BYTESEL_ALL);
         bus_data_r  <= rd_s ? rdata_s : 32'd0;
      end
   end

   // Register writes first (W1C before START), then the sequencer overlays its updates.
   always_comb begin
      state_nx_s   = state_r;
      src_nx_s     = src_r;
      dst_nx_s     = dst_r;
      count_nx_s   = count_r;
      done_nx_s    = done_r;
      err_nx_s     = err_r;
      irq_en_nx_s  = irq_en_r;
      src_inc_nx_s = src_inc_r;
      dst_inc_nx_s = dst_inc_r;
      req_s        = 1'b0;
      req_addr_s   = 30'd0;
      req_wr_en_s  = 1'b0;
      req_wr_val_s = 32'd0;

      if (wr_s) begin
         case (reg_sel_s)
            REG_SRC:   src_nx_s   = busy_s ? src_r   : bus_wr_val[29:0];
            REG_DST:   dst_nx_s   = busy_s ? dst_r   : bus_wr_val[29:0];
            REG_COUNT: count_nx_s = busy_s ? count_r : bus_wr_val[15:0];
            REG_CTRL: begin
               done_nx_s   = done_r && !bus_wr_val[CTRL_DONE];
               err_nx_s    = err_r && !bus_wr_val[CTRL_ERR];
               irq_en_nx_s = bus_wr_val[CTRL_IRQ_EN];
               if (!busy_s) begin
                  src_inc_nx_s = bus_wr_val[CTRL_SRC_INC];
                  dst_inc_nx_s = bus_wr_val[CTRL_DST_INC];
               end else begin
                  src_inc_nx_s = src_inc_r;
                  dst_inc_nx_s = dst_inc_r;
               end
            end
            default: state_nx_s = state_r;
         endcase
      end else begin
         state_nx_s = state_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (start_s && (count_r != 16'd0)) begin
               state_nx_s = ST_RD_REQ;
               req_s      = 1'b1;
               req_addr_s = src_r;
            end else if (start_s) begin
               state_nx_s = ST_FIN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RD_REQ: state_nx_s = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (xfer_err_s) begin
               state_nx_s = ST_ERRS;
               err_nx_s   = 1'b1;
            end else if (xfer_done_s) begin
               // Read data goes straight into the write request's data register.
               state_nx_s   = ST_WR_REQ;
               req_s        = 1'b1;
               req_addr_s   = dst_r;
               req_wr_en_s  = 1'b1;
               req_wr_val_s = m_data;
            end else begin
               state_nx_s = ST_RD_WAIT;
            end
         end
         ST_WR_REQ: state_nx_s = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (xfer_err_s) begin
               state_nx_s = ST_ERRS;
               err_nx_s   = 1'b1;
            end else if (xfer_done_s) begin
               count_nx_s = count_r - 16'd1;
               src_nx_s   = ptr_step(src_r, src_inc_r);
               dst_nx_s   = ptr_step(dst_r, dst_inc_r);
               if (count_r == 16'd1) begin
                  state_nx_s = ST_FIN;
               end else begin
                  state_nx_s = ST_RD_REQ;
                  req_s      = 1'b1;
                  req_addr_s = ptr_step(src_r, src_inc_r);
               end
            end else begin
               state_nx_s = ST_WR_WAIT;
            end
         end
         ST_FIN: begin
            done_nx_s  = 1'b1;
            state_nx_s = ST_IDLE;
         end
         ST_ERRS: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase

      irq_nx_s = irq_en_nx_s && (done_nx_s || err_nx_s);
   end

   // Sequencer state and register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         src_r     <= 30'd0;
         dst_r     <= 30'd0;
         count_r   <= 16'd0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         irq_en_r  <= 1'b0;
         src_inc_r <= 1'b0;
         dst_inc_r <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         src_r     <= src_nx_s;
         dst_r     <= dst_nx_s;
         count_r   <= count_nx_s;
         done_r    <= done_nx_s;
         err_r     <= err_nx_s;
         irq_en_r  <= irq_en_nx_s;
         src_inc_r <= src_inc_nx_s;
         dst_inc_r <= dst_inc_nx_s;
         irq_r     <= irq_nx_s;
      end
   end

   keynsham_bus_initiator #(.timeout_cycles(timeout_cycles)) u_init (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_s),
      .req_addr   (req_addr_s),
      .req_wr_en  (req_wr_en_s),
      .req_wr_val (req_wr_val_s),
      .m_access   (m_access),
      .m_addr     (m_addr),
      .m_wr_en    (m_wr_en),
      .m_wr_val   (m_wr_val),
      .m_bytesel  (m_bytesel),
      .m_ack      (m_ack),
      .m_error    (m_error),
      .xfer_done  (xfer_done_s),
      .xfer_err   (xfer_err_s)
   );

   assign bus_cs    = cs_s;
   assign bus_ack   = bus_ack_r;
   assign bus_error = bus_error_r;
   assign bus_data  = bus_data_r;
   assign irq       = irq_r;

endmodule

// File: tb/tb_keynsham_dma.sv
// tb_keynsham_dma
// Directed bench for keynsham_dma with a small single-cycle-ack memory responder.
module tb_keynsham_dma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_access = 1'b0;
   logic        bus_cs;
   logic [29:0] bus_addr = 30'h100;
   logic [31:0] bus_wr_val = 32'd0;
   logic        bus_wr_en = 1'b0;
   logic [3:0]  bus_bytesel = 4'd0;
   logic        bus_ack, bus_error;
   logic [31:0] bus_data;
   logic        m_access, m_wr_en;
   logic [29:0] m_addr;
   logic [31:0] m_wr_val;
   logic [3:0]  m_bytesel;
   logic [31:0] m_data = 32'd0;
   logic        m_ack = 1'b0;
   logic        m_error = 1'b0;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Responder state: 0 ack all, 1 never respond, 2 error on 2nd read, 3 ack reads only
   int          resp_mode = 0;
   int          rd_cnt = 0;
   logic [31:0] mem [0:4095];
   logic [31:0] acc_q [$];
   logic        seen = 1'b0;
   logic        seen_wr = 1'b0;
   logic [29:0] seen_addr = 30'd0;
   logic [31:0] seen_val = 32'd0;

   always #5 clk = ~clk;

   keynsham_dma #(.bus_address(32'h0), .bus_size(32'h10), .timeout_cycles(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus_access(bus_access), .bus_cs(bus_cs),
      .bus_addr(bus_addr), .bus_wr_val(bus_wr_val), .bus_wr_en(bus_wr_en),
      .bus_bytesel(bus_bytesel), .bus_ack(bus_ack), .bus_error(bus_error),
      .bus_data(bus_data), .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en),
      .m_wr_val(m_wr_val), .m_bytesel(m_bytesel), .m_data(m_data), .m_ack(m_ack),
      .m_error(m_error), .irq(irq)
   );

   // capture requests mid-cycle
   always @(negedge clk) begin
      if (m_access === 1'b1) begin
         seen      = 1'b1;
         seen_wr   = m_wr_en;
         seen_addr = m_addr;
         seen_val  = m_wr_val;
         acc_q.push_back({m_wr_en, 1'b0, m_addr});
      end
   end

   // respond during the cycle after the request
   always @(posedge clk) begin
      #1;
      m_ack   = 1'b0;
      m_error = 1'b0;
      m_data  = 32'd0;
      if (seen) begin
         seen = 1'b0;
         if (!seen_wr) begin
            rd_cnt++;
            if (resp_mode == 2 && rd_cnt == 2) m_error = 1'b1;
            else if (resp_mode != 1) begin
               m_ack  = 1'b1;
               m_data = mem[seen_addr[11:0]];
            end
         end else if (resp_mode == 0 || resp_mode == 2) begin
            m_ack = 1'b1;
            mem[seen_addr[11:0]] = seen_val;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bs,
                         output logic ack, output logic err);
      @(negedge clk);
      bus_access = 1'b1; bus_addr = a; bus_wr_val = d; bus_wr_en = 1'b1; bus_bytesel = bs;
      @(negedge clk);
      ack = bus_ack; err = bus_error;
      bus_access = 1'b0; bus_addr = 30'h100; bus_wr_val = 32'd0; bus_wr_en = 1'b0; bus_bytesel = 4'd0;
   endtask

   task automatic bus_rd(input logic [29:0] a, input logic [3:0] bs,
                         output logic [31:0] d, output logic ack, output logic err);
      @(negedge clk);
      bus_access = 1'b1; bus_addr = a; bus_wr_en = 1'b0; bus_bytesel = bs;
      @(negedge clk);
      d = bus_data; ack = bus_ack; err = bus_error;
      bus_access = 1'b0; bus_addr = 30'h100; bus_bytesel = 4'd0;
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d);
      logic ack, err;
      bus_wr(a, d, 4'b1111, ack, err);
   endtask

   task automatic rd_check(input string tag, input logic [29:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic ack, err;
      bus_rd(a, 4'b1111, d, ack, err);
      check(tag, d, exp);
   endtask

   task automatic wait_irq(input int lim, output int n);
      n = 0;
      while (irq !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        ack, err;
      logic [31:0] d;
      logic [29:0] a;

      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_outs", {27'd0, m_access, m_wr_en, irq, bus_ack, bus_cs}, 32'd0);
      check("rst_maddr", {2'b00, m_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_check("rst_src", 30'd0, 32'd0);
      rd_check("rst_ctrl", 30'd3, 32'd0);
      bus_addr = 30'd3; #1;
      check("cs_in", {31'd0, bus_cs}, 32'd1);
      bus_addr = 30'd4; #1;
      check("cs_out", {31'd0, bus_cs}, 32'd0);
      bus_addr = 30'h100;

      // 4-word incrementing copy
      wr(30'd0, 32'h0800_0000);
      wr(30'd1, 32'h0800_0400);
      wr(30'd2, 32'd4);
      acc_q.delete();
      wr(30'd3, 32'h39);
      wait_irq(100, n);
      check("xfer_cycles", 32'(n), 32'd17);
      check("xfer_nacc", 32'(acc_q.size()), 32'd8);
      for (int i = 0; i < 4; i++) begin
         a = 30'h0800_0000 + 30'(i);
         check($sformatf("rd_order%0d", i), acc_q[2*i], {2'b00, a});
         a = 30'h0800_0400 + 30'(i);
         check($sformatf("wr_order%0d", i), acc_q[2*i+1], {2'b10, a});
         check($sformatf("copy%0d", i), mem[12'h400 + 12'(i)], 32'hA5A5_0000 + 32'(i) * 32'h0101);
      end
      rd_check("done_ctrl", 30'd3, 32'h3A);
      rd_check("done_src", 30'd0, 32'h0800_0004);
      rd_check("done_cnt", 30'd2, 32'd0);

      // W1C DONE drops irq the next cycle
      check("irq_before_w1c", {31'd0, irq}, 32'd1);
      wr(30'd3, 32'h3A);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);
      rd_check("w1c_ctrl", 30'd3, 32'h38);

      // COUNT = 0
      wr(30'd2, 32'd0);
      acc_q.delete();
      wr(30'd3, 32'h39);
      check("zero_irq_c1", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("zero_irq_c2", {31'd0, irq}, 32'd1);
      rd_check("zero_ctrl", 30'd3, 32'h3A);
      check("zero_noacc", 32'(acc_q.size()), 32'd0);
      wr(30'd3, 32'h3A);

      // bus error on second read
      resp_mode = 2; rd_cnt = 0;
      wr(30'd0, 32'h0800_0000);
      wr(30'd1, 32'h0800_0400);
      wr(30'd2, 32'd4);
      acc_q.delete();
      wr(30'd3, 32'h39);
      wait_irq(100, n);
      check("err_irq", {31'd0, irq}, 32'd1);
      repeat (20) @(negedge clk);
      check("err_nacc", 32'(acc_q.size()), 32'd3);
      check("err_macc", {31'd0, m_access}, 32'd0);
      rd_check("err_ctrl", 30'd3, 32'h3C);
      rd_check("err_src", 30'd0, 32'h0800_0001);
      rd_check("err_dst", 30'd1, 32'h0800_0401);
      rd_check("err_cnt", 30'd2, 32'd3);
      wr(30'd3, 32'h3C);
      check("err_w1c_irq", {31'd0, irq}, 32'd0);

      // timeout with a silent responder
      resp_mode = 1;
      wr(30'd0, 32'h0800_0010);
      wr(30'd2, 32'd1);
      acc_q.delete();
      wr(30'd3, 32'h39);
      check("tmo_req", {31'd0, m_access}, 32'd1);
      repeat (8) @(negedge clk);
      check("tmo_irq_c8", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("tmo_irq_c9", {31'd0, irq}, 32'd1);
      repeat (5) @(negedge clk);
      check("tmo_nacc", 32'(acc_q.size()), 32'd1);
      check("tmo_macc", {31'd0, m_access}, 32'd0);
      rd_check("tmo_ctrl", 30'd3, 32'h3C);
      wr(30'd3, 32'h3C);

      // DST write while busy, then reset in WR_WAIT
      resp_mode = 3;
      wr(30'd0, 32'h0800_0000);
      wr(30'd1, 32'h0800_0400);
      wr(30'd2, 32'd2);
      wr(30'd3, 32'h39);
      bus_wr(30'd1, 32'h0000_0ABC, 4'b1111, ack, err);
      check("busy_wr_ack", {30'd0, ack, err}, 32'd2);
      rd_check("busy_dst", 30'd1, 32'h0800_0400);
      check("hold_wren", {31'd0, m_wr_en}, 32'd1);
      check("hold_addr", {2'b00, m_addr}, 32'h0800_0400);
      check("hold_val", m_wr_val, 32'hA5A5_0000);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl", {26'd0, m_access, m_wr_en, irq, bus_ack, bus_error, bus_cs}, 32'd0);
      check("arst_addr", {2'b00, m_addr}, 32'd0);
      check("arst_val", m_wr_val, 32'd0);
      check("arst_bsel", {28'd0, m_bytesel}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      resp_mode = 0;
      acc_q.delete();
      repeat (5) @(negedge clk);
      check("arst_noacc", 32'(acc_q.size()), 32'd0);
      rd_check("arst_src", 30'd0, 32'd0);
      rd_check("arst_dst", 30'd1, 32'd0);
      rd_check("arst_cnt", 30'd2, 32'd0);
      rd_check("arst_ctrl", 30'd3, 32'd0);

      // partial byte lanes
      bus_wr(30'd0, 32'h0000_0123, 4'b0011, ack, err);
      check("bsel_wr", {30'd0, ack, err}, 32'd3);
      rd_check("bsel_src", 30'd0, 32'd0);
      bus_rd(30'd3, 4'b0011, d, ack, err);
      check("bsel_rd", {30'd0, ack, err}, 32'd3);
      check("bsel_rd_data", d, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
